// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter slice.
//
// Contents:
//   WB_*            default widths / depths used by wb_arbiter and wb_result_fifo
//   REG_ZERO        architectural zero register index (never written)
//   wb_entry_t      one buffered long-latency result (addr, data, live)
//
// wb_entry_t fields are sized by WB_ADDR_WIDTH / WB_DATA_WIDTH. Instances that
// override ADDR_WIDTH / DATA_WIDTH must keep them within these widths.
//
// Optional feature macro used by this slice: WB_BYPASS_EN (see wb_arbiter).
package wb_pkg;

    localparam int WB_DATA_WIDTH   = 32;
    localparam int WB_ADDR_WIDTH   = 5;
    localparam int WB_FIFO_DEPTH   = 4;
    localparam int WB_STARVE_LIMIT = 8;

    localparam int unsigned REG_ZERO = 0;

    // live=0 marks an entry superseded by a younger pipeline write to the
    // same register; it still occupies a slot until it reaches the head.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
        logic                     live;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small buffer for out-of-order long-latency results.
//
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   push, push_addr/push_data write a new live entry (ignored when full)
//   pop                       retire the head entry (ignored when empty)
//   kill_en, kill_addr        mark every stored entry targeting kill_addr dead
//   q_addr, q_pending         combinational "live entry targets q_addr" query
//   full, empty               derived from the registered occupancy counter
//   head_live, head_addr,
//   head_data                 current head entry
//
// Pointers are plain binary and wrap at FIFO_DEPTH (a power of two); the
// occupancy counter runs 0..FIFO_DEPTH so full and empty are unambiguous.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [ADDR_WIDTH-1:0] kill_addr,
    input  logic [ADDR_WIDTH-1:0] q_addr,
    output logic                  q_pending,
    output logic                  full,
    output logic                  empty,
    output logic                  head_live,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = ADDR_WIDTH'(REG_ZERO);

    wb_entry_t             mem [FIFO_DEPTH];
    wb_entry_t             head_entry;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] occupied;
    logic [FIFO_DEPTH-1:0] kill_vec;
    logic [FIFO_DEPTH-1:0] match_vec;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_entry = mem[rd_ptr];
    assign head_live  = !empty && head_entry.live;
    assign head_addr  = ADDR_WIDTH'(head_entry.addr);
    assign head_data  = DATA_WIDTH'(head_entry.data);

    // A slot holds a real entry when its distance from the read pointer is
    // below the occupancy. Everything else in mem is stale and must be
    // ignored, which is why the storage array itself needs no reset.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset    = '0;
        occupied  = '0;
        kill_vec  = '0;
        match_vec = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset       = PTR_W'(i) - rd_ptr;
            occupied[i]  = ({1'b0, offset} < count);
            kill_vec[i]  = kill_en && occupied[i] &&
                           (mem[i].addr == WB_ADDR_WIDTH'(kill_addr));
            match_vec[i] = occupied[i] && mem[i].live &&
                           (mem[i].addr == WB_ADDR_WIDTH'(q_addr));
        end
    end

    // Uses only registered state, so an entry being pushed this cycle is
    // not yet visible to the hazard query.
    assign q_pending = (|match_vec) && (q_addr != ZERO_ADDR);

    // Entry storage. The kill vector only covers occupied slots and a push
    // only targets an unoccupied slot, so a result pushed in the same cycle
    // as a kill to its register always lands live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (kill_vec[i]) begin
                mem[i].live <= 1'b0;
            end
        end
        if (do_push) begin
            mem[wr_ptr].addr <= WB_ADDR_WIDTH'(push_addr);
            mem[wr_ptr].data <= WB_DATA_WIDTH'(push_data);
            mem[wr_ptr].live <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: drives the register file's single write port from the in-order
// pipeline and from buffered out-of-order long-latency results.
//
// Ports:
//   clock, reset_n                       clock / asynchronous active-low reset
//   pipe_wr_en, pipe_wr_addr,
//   pipe_wr_data                         in-order result, never back-pressured
//   lat_valid, lat_ready, lat_addr,
//   lat_data                             long-latency valid/ready handshake
//   stall_req                            one-cycle request to idle the pipeline
//   q_addr, q_pending                    hazard query (combinational)
//   rf_we, rf_addr, rf_data              registered register-file write port
//   byp_valid, byp_addr, byp_data        pre-register selected write
//                                        (present only with WB_BYPASS_EN)
//
// Priority each cycle: pipeline write, then live FIFO head, then discard a
// dead FIFO head. Writes to register zero are never stored or issued.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pipe_wr_en,
    input  logic [ADDR_WIDTH-1:0] pipe_wr_addr,
    input  logic [DATA_WIDTH-1:0] pipe_wr_data,
    input  logic                  lat_valid,
    output logic                  lat_ready,
    input  logic [ADDR_WIDTH-1:0] lat_addr,
    input  logic [DATA_WIDTH-1:0] lat_data,
    output logic                  stall_req,
    input  logic [ADDR_WIDTH-1:0] q_addr,
    output logic                  q_pending,
`ifdef WB_BYPASS_EN
    output logic                  byp_valid,
    output logic [ADDR_WIDTH-1:0] byp_addr,
    output logic [DATA_WIDTH-1:0] byp_data,
`endif
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);

    logic                  pipe_sel;
    logic                  head_issue;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_live;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STARVE_W-1:0]   starve_cnt;

    // Ready comes from registered occupancy only, so a full buffer refuses
    // a push even in a cycle where it also pops.
    assign lat_ready = !fifo_full;
    assign fifo_push = lat_valid && lat_ready && (lat_addr != ZERO_ADDR);

    wb_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_addr (lat_addr),
        .push_data (lat_data),
        .pop       (fifo_pop),
        .kill_en   (pipe_sel),
        .kill_addr (pipe_wr_addr),
        .q_addr    (q_addr),
        .q_pending (q_pending),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    // A pipeline write to register zero counts as idle so the buffer can
    // drain in that slot. Whenever the pipeline does not write, the head is
    // popped whether live (issued) or dead (dropped without a write).
    always_comb begin
        pipe_sel   = pipe_wr_en && (pipe_wr_addr != ZERO_ADDR);
        head_issue = !pipe_sel && head_live;
        fifo_pop   = !pipe_sel && !fifo_empty;
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        if (pipe_sel) begin
            sel_we   = 1'b1;
            sel_addr = pipe_wr_addr;
            sel_data = pipe_wr_data;
        end else if (head_issue) begin
            sel_we   = 1'b1;
            sel_addr = head_addr;
            sel_data = head_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = sel_we;
    assign byp_addr  = sel_addr;
    assign byp_data  = sel_data;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we   <= sel_we;
            rf_addr <= sel_addr;
            rf_data <= sel_data;
        end
    end

    // Counts cycles a live head is passed over. On reaching the limit it
    // raises stall_req for one cycle and restarts; the pipeline then leaves
    // a slot free the following cycle in which the head is issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            stall_req <= 1'b0;
            if (fifo_pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (head_live && !head_issue) begin
                if (starve_cnt == STARVE_LAST) begin
                    starve_cnt <= '0;
                    stall_req  <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (default build,
// WB_BYPASS_EN undefined). Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, away from the active edge.
module tb_wb_arbiter;

    logic        clock;
    logic        reset_n;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_addr;
    logic [31:0] lat_data;
    logic        stall_req;
    logic [4:0]  q_addr;
    logic        q_pending;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int compareCount;
    int failCount;

    wb_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (5),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .pipe_wr_data (pipe_wr_data),
        .lat_valid    (lat_valid),
        .lat_ready    (lat_ready),
        .lat_addr     (lat_addr),
        .lat_data     (lat_data),
        .stall_req    (stall_req),
        .q_addr       (q_addr),
        .q_pending    (q_pending),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic pEn, input logic [4:0] pAddr,
                                 input logic [31:0] pData, input logic lValid,
                                 input logic [4:0] lAddr, input logic [31:0] lData);
        pipe_wr_en   = pEn;
        pipe_wr_addr = pAddr;
        pipe_wr_data = pData;
        lat_valid    = lValid;
        lat_addr     = lAddr;
        lat_data     = lData;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic [4:0] addr,
                              input logic [31:0] data);
        checkOutput({tag, "_we"}, 32'(rf_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(rf_addr), 32'(addr));
        checkOutput({tag, "_data"}, rf_data, data);
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        reset_n      = 1'b0;
        q_addr       = 5'd0;
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);

        // 1: reset holds outputs even with a pipeline write presented
        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_we", 32'(rf_we), 32'd0);
        checkOutput("rst_addr", 32'(rf_addr), 32'd0);
        checkOutput("rst_data", rf_data, 32'd0);
        checkOutput("rst_ready", 32'(lat_ready), 32'd1);
        checkOutput("rst_stall", 32'(stall_req), 32'd0);
        reset_n = 1'b1;
        tick();
        checkWrite("rel", 5'd5, 32'h55);

        // 2: pipeline wins while two results are buffered, then they drain
        $display("[TB] buffered drain");
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd3, 32'hAA);
        tick();
        checkWrite("p7a", 5'd7, 32'h70);
        applyStimulus(1'b1, 5'd7, 32'h71, 1'b1, 5'd4, 32'hBB);
        tick();
        checkWrite("p7b", 5'd7, 32'h71);
        q_addr = 5'd3;
        #1;
        checkOutput("pend3", 32'(q_pending), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("l3", 5'd3, 32'hAA);
        tick();
        checkWrite("l4", 5'd4, 32'hBB);
        tick();
        checkOutput("idle2_we", 32'(rf_we), 32'd0);
        checkOutput("pend3_gone", 32'(q_pending), 32'd0);

        // 3: write-after-write kill of a buffered result
        $display("[TB] waw kill");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h11);
        tick();
        checkOutput("push9_we", 32'(rf_we), 32'd0);
        q_addr = 5'd9;
        #1;
        checkOutput("pend9", 32'(q_pending), 32'd1);
        applyStimulus(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("p9", 5'd9, 32'h22);
        checkOutput("pend9_kill", 32'(q_pending), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("dead_pop_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("dead_after_we", 32'(rf_we), 32'd0);

        // 4: full buffer refuses a push even while popping
        $display("[TB] full");
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd10, 32'hA0);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd11, 32'hA1);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd12, 32'hA2);
        tick();
        checkOutput("ready3", 32'(lat_ready), 32'd1);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd13, 32'hA3);
        tick();
        checkOutput("ready_full", 32'(lat_ready), 32'd0);
        checkWrite("p7full", 5'd7, 32'h77);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hA4);
        tick();
        checkWrite("l10", 5'd10, 32'hA0);
        checkOutput("ready_back", 32'(lat_ready), 32'd1);
        q_addr = 5'd14;
        #1;
        checkOutput("pend14", 32'(q_pending), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("l11", 5'd11, 32'hA1);
        tick();
        checkWrite("l12", 5'd12, 32'hA2);
        tick();
        checkWrite("l13", 5'd13, 32'hA3);
        tick();
        checkOutput("refused_we", 32'(rf_we), 32'd0);

        // 5: starvation request after 8 passed-over cycles
        $display("[TB] starvation");
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd20, 32'hC0);
        tick();
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
        repeat (7) tick();
        checkOutput("stall_early", 32'(stall_req), 32'd0);
        tick();
        checkOutput("stall_pulse", 32'(stall_req), 32'd1);
        checkWrite("p6", 5'd6, 32'h66);
        tick();
        checkOutput("stall_drop", 32'(stall_req), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("l20", 5'd20, 32'hC0);

        // 6: register zero on both sources
        $display("[TB] register zero");
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd21, 32'hD1);
        tick();
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd22, 32'hD2);
        tick();
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd23, 32'hD3);
        tick();
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd0, 32'hBEEF);
        tick();
        checkOutput("zero_push_ready", 32'(lat_ready), 32'd1);
        checkWrite("p8", 5'd8, 32'h88);
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("l21", 5'd21, 32'hD1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkWrite("l22", 5'd22, 32'hD2);
        tick();
        checkWrite("l23", 5'd23, 32'hD3);
        tick();
        checkOutput("zero_drain_we", 32'(rf_we), 32'd0);
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        tick();
        checkOutput("zero_both_we", 32'(rf_we), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("zero_none_we", 32'(rf_we), 32'd0);
        q_addr = 5'd0;
        #1;
        checkOutput("pend0", 32'(q_pending), 32'd0);

        // reset mid-operation discards buffered results
        $display("[TB] mid-run reset");
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd25, 32'hE5);
        tick();
        q_addr = 5'd25;
        #1;
        checkOutput("pend25", 32'(q_pending), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("mrst_we", 32'(rf_we), 32'd0);
        checkOutput("mrst_pend", 32'(q_pending), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("mrst_after_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("mrst_after2_we", 32'(rf_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
